// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter_if
//  Description : Writeback bus bundle: EX and LSU producer handshakes plus the
//                register file write port driven by the arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface wb_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              ex_valid;
    logic [ADDR_W-1:0] ex_waddr;
    logic [DATA_W-1:0] ex_wdata;
    logic              ex_ready;

    logic              lsu_valid;
    logic [ADDR_W-1:0] lsu_waddr;
    logic [DATA_W-1:0] lsu_wdata;
    logic              lsu_ready;

    logic [ADDR_W-1:0] rd_waddr;
    logic [DATA_W-1:0] rd_wdata;
    logic              wen;

    // Arbiter side
    modport slave (
        input  ex_valid, ex_waddr, ex_wdata,
        output ex_ready,
        input  lsu_valid, lsu_waddr, lsu_wdata,
        output lsu_ready,
        output rd_waddr, rd_wdata, wen
    );

    // Producer / register-file side
    modport master (
        output ex_valid, ex_waddr, ex_wdata,
        input  ex_ready,
        output lsu_valid, lsu_waddr, lsu_wdata,
        input  lsu_ready,
        input  rd_waddr, rd_wdata, wen
    );
endinterface
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter
//  Description : Shares the register file write port between EX and LSU.
//                LSU has priority; define WB_STARVE_GUARD_EN to compile in
//                the EX starvation guard (forced EX win after STARVE_MAX).
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input  wire logic       clk,
    input  wire logic       rstn,
    wb_arbiter_if.slave     bus
);

    logic              w_ex_grant;
    logic              w_lsu_grant;
    logic              w_force_ex;
    logic              w_grant;
    logic [ADDR_W-1:0] w_sel_waddr;
    logic [DATA_W-1:0] w_sel_wdata;

    logic              r_wen;
    logic [ADDR_W-1:0] r_rd_waddr;
    logic [DATA_W-1:0] r_rd_wdata;

`ifdef WB_STARVE_GUARD_EN
    localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);

    logic [3:0] r_starve_cnt;

    assign w_force_ex = (r_starve_cnt == C_STARVE_MAX);

    // EX is granted at the latest when the count hits C_STARVE_MAX, so the
    // counter can never advance past it and needs no saturation.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_starve_cnt <= 4'd0;
        end else if (bus.ex_valid && !w_ex_grant) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end else begin
            r_starve_cnt <= 4'd0;
        end
    end
`else
    logic w_unused_starve_max;

    assign w_force_ex          = 1'b0;
    assign w_unused_starve_max = (STARVE_MAX > 0);
`endif

    always_comb begin
        w_ex_grant  = 1'b0;
        w_lsu_grant = 1'b0;
        if (rstn) begin
            w_ex_grant  = bus.ex_valid && (!bus.lsu_valid || w_force_ex);
            w_lsu_grant = bus.lsu_valid && !w_ex_grant;
        end
    end

    assign w_grant     = w_ex_grant || w_lsu_grant;
    assign w_sel_waddr = w_ex_grant ? bus.ex_waddr : bus.lsu_waddr;
    assign w_sel_wdata = w_ex_grant ? bus.ex_wdata : bus.lsu_wdata;

    // x0 transfers are still captured into the address/data registers but
    // never raise the write enable.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wen      <= 1'b0;
            r_rd_waddr <= '0;
            r_rd_wdata <= '0;
        end else if (w_grant) begin
            r_wen      <= (w_sel_waddr != '0);
            r_rd_waddr <= w_sel_waddr;
            r_rd_wdata <= w_sel_wdata;
        end else begin
            r_wen      <= 1'b0;
        end
    end

    assign bus.ex_ready  = w_ex_grant;
    assign bus.lsu_ready = w_lsu_grant;
    assign bus.wen       = r_wen;
    assign bus.rd_waddr  = r_rd_waddr;
    assign bus.rd_wdata  = r_rd_wdata;

    a_one_grant : assert property (@(posedge clk) !(w_ex_grant && w_lsu_grant));

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_arbiter
//  Description : Directed self-checking bench for wb_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    localparam int ADDR_W     = 5;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 3;

    logic clk;
    logic rstn;
    int   n_checks;
    int   n_fail;

    wb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    wb_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance into the next cycle; inputs change 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ex_valid  = 1'b0;
        bus.ex_waddr  = '0;
        bus.ex_wdata  = '0;
        bus.lsu_valid = 1'b0;
        bus.lsu_waddr = '0;
        bus.lsu_wdata = '0;
    endtask

    task automatic test_reset();
        rstn          = 1'b0;
        bus.ex_valid  = 1'b1;
        bus.ex_waddr  = 5'd6;
        bus.ex_wdata  = 32'h1234_5678;
        bus.lsu_valid = 1'b1;
        bus.lsu_waddr = 5'd7;
        bus.lsu_wdata = 32'h8765_4321;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (bus.ex_ready !== 1'b0 || bus.lsu_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ready cyc%0d: ex_ready=%b lsu_ready=%b required 0/0", i, bus.ex_ready, bus.lsu_ready);
            end
            n_checks++;
            if (bus.wen !== 1'b0 || bus.rd_waddr !== 5'd0 || bus.rd_wdata !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_outputs cyc%0d: wen=%b waddr=%0d wdata=%h required 0/0/0", i, bus.wen, bus.rd_waddr, bus.rd_wdata);
            end
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle_inputs();
    endtask

    task automatic test_single_ex();
        cyc();
        bus.ex_valid = 1'b1;
        bus.ex_waddr = 5'd5;
        bus.ex_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_checks++;
        if (bus.ex_ready !== 1'b1 || bus.lsu_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ex_ready: ex_ready=%b lsu_ready=%b required 1/0", bus.ex_ready, bus.lsu_ready);
        end
        cyc();
        bus.ex_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.wen !== 1'b1 || bus.rd_waddr !== 5'd5 || bus.rd_wdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL single_ex_write: wen=%b waddr=%0d wdata=%h required 1/5/deadbeef", bus.wen, bus.rd_waddr, bus.rd_wdata);
        end
        cyc();
        @(negedge clk);
        n_checks++;
        if (bus.wen !== 1'b0 || bus.rd_waddr !== 5'd5 || bus.rd_wdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL single_ex_idle: wen=%b waddr=%0d wdata=%h required 0/5/deadbeef (hold)", bus.wen, bus.rd_waddr, bus.rd_wdata);
        end
    endtask

    task automatic test_contention();
        cyc();
        bus.lsu_valid = 1'b1;
        bus.lsu_waddr = 5'd3;
        bus.lsu_wdata = 32'h11;
        bus.ex_valid  = 1'b1;
        bus.ex_waddr  = 5'd4;
        bus.ex_wdata  = 32'h22;
        @(negedge clk);
        n_checks++;
        if (bus.lsu_ready !== 1'b1 || bus.ex_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL contention_n: lsu_ready=%b ex_ready=%b required 1/0", bus.lsu_ready, bus.ex_ready);
        end
        cyc();
        bus.lsu_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.ex_ready !== 1'b1 || bus.lsu_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL contention_n1_ready: ex_ready=%b lsu_ready=%b required 1/0", bus.ex_ready, bus.lsu_ready);
        end
        n_checks++;
        if (bus.wen !== 1'b1 || bus.rd_waddr !== 5'd3 || bus.rd_wdata !== 32'h11) begin
            n_fail++;
            $display("FAIL contention_lsu_write: wen=%b waddr=%0d wdata=%h required 1/3/11", bus.wen, bus.rd_waddr, bus.rd_wdata);
        end
        cyc();
        bus.ex_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.wen !== 1'b1 || bus.rd_waddr !== 5'd4 || bus.rd_wdata !== 32'h22) begin
            n_fail++;
            $display("FAIL contention_ex_write: wen=%b waddr=%0d wdata=%h required 1/4/22", bus.wen, bus.rd_waddr, bus.rd_wdata);
        end
        cyc();
    endtask

    task automatic test_starvation();
        cyc();
        bus.lsu_valid = 1'b1;
        bus.lsu_waddr = 5'd7;
        bus.lsu_wdata = 32'h0000_0777;
        bus.ex_valid  = 1'b1;
        bus.ex_waddr  = 5'd8;
        bus.ex_wdata  = 32'h0000_0888;
`ifdef WB_STARVE_GUARD_EN
        for (int i = 0; i < STARVE_MAX; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.ex_ready !== 1'b0 || bus.lsu_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL starve_denied N+%0d: ex_ready=%b lsu_ready=%b required 0/1", i, bus.ex_ready, bus.lsu_ready);
            end
            cyc();
        end
        @(negedge clk);
        n_checks++;
        if (bus.ex_ready !== 1'b1 || bus.lsu_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL starve_forced: ex_ready=%b lsu_ready=%b required 1/0", bus.ex_ready, bus.lsu_ready);
        end
        cyc();
        bus.ex_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.lsu_ready !== 1'b1 || bus.ex_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL starve_lsu_resume: lsu_ready=%b ex_ready=%b required 1/0", bus.lsu_ready, bus.ex_ready);
        end
        n_checks++;
        if (bus.wen !== 1'b1 || bus.rd_waddr !== 5'd8 || bus.rd_wdata !== 32'h0000_0888) begin
            n_fail++;
            $display("FAIL starve_ex_write: wen=%b waddr=%0d wdata=%h required 1/8/888", bus.wen, bus.rd_waddr, bus.rd_wdata);
        end
`else
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.ex_ready !== 1'b0 || bus.lsu_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL strict_priority N+%0d: ex_ready=%b lsu_ready=%b required 0/1", i, bus.ex_ready, bus.lsu_ready);
            end
            cyc();
        end
        bus.ex_valid = 1'b0;
`endif
        cyc();
        bus.lsu_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.wen !== 1'b1 || bus.rd_waddr !== 5'd7 || bus.rd_wdata !== 32'h0000_0777) begin
            n_fail++;
            $display("FAIL starve_lsu_write: wen=%b waddr=%0d wdata=%h required 1/7/777", bus.wen, bus.rd_waddr, bus.rd_wdata);
        end
        cyc();
    endtask

    task automatic test_x0_write();
        cyc();
        bus.ex_valid = 1'b1;
        bus.ex_waddr = 5'd0;
        bus.ex_wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        n_checks++;
        if (bus.ex_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL x0_ready: ex_ready=%b required 1", bus.ex_ready);
        end
        cyc();
        bus.ex_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.wen !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_wen: wen=%b required 0", bus.wen);
        end
        cyc();
    endtask

    task automatic test_mid_reset();
        cyc();
        bus.lsu_valid = 1'b1;
        bus.lsu_waddr = 5'd9;
        bus.lsu_wdata = 32'h99;
        @(negedge clk);
        n_checks++;
        if (bus.lsu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_ready: lsu_ready=%b required 1", bus.lsu_ready);
        end
        rstn = 1'b0;
        @(posedge clk);
        #1;
        bus.lsu_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.wen !== 1'b0 || bus.rd_waddr !== 5'd0 || bus.rd_wdata !== 32'd0) begin
            n_fail++;
            $display("FAIL midrst_dropped: wen=%b waddr=%0d wdata=%h required 0/0/0", bus.wen, bus.rd_waddr, bus.rd_wdata);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rstn     = 1'b0;
        idle_inputs();
        test_reset();
        test_single_ex();
        test_contention();
        test_starvation();
        test_x0_write();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
